md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit and its control for the E stage of the pipelined MIPS core.
- Decodes SPECIAL-class HI/LO instructions (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) directly from the instruction word.
- Runs a parametrised multi-cycle busy counter and holds HI/LO.
- Generates the D-stage stall request for HI/LO-class instructions, so the main decoder only needs to route mf_data to the writeback mux.

Parameters:
- DATA_W, 32, operand/HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- e_instr  in  32  instruction in E stage
- e_valid  in  1  E instruction is real (not bubble/flushed)
- rs_val  in  DATA_W  forwarded GPR[rs]
- rt_val  in  DATA_W  forwarded GPR[rt]
- d_instr  in  32  instruction in D stage (stall query only)
- busy  out  1  operation in progress
- start  out  1  E instr launches mult/div this cycle (combinational)
- stall  out  1  D-stage stall request (combinational)
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- mf_data  out  DATA_W  mfhi→hi, mflo→lo, else 0 (combinational from e_instr)

Behaviour:
- Decode: op=000000 with funct mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. Everything else is non-MD and has no effect.
- is_md(x) is true for any of those 8 in x (plus the Optional Feature ops).
- Reset: hi=0, lo=0, counter=0, pending regs=0; busy=0. Async assert clears everything immediately, including an operation in flight; the result is lost.
- start = e_valid & (mult|multu|div|divu in e_instr) & !busy.
- On the start edge:
  - Compute the result into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0). busy stays high for exactly N cycles after the start edge.
- On the edge where counter goes 1→0: hi<=pend_hi, lo<=pend_lo. The new values are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 2·DATA_W product; hi = upper half, lo = lower half.
  - multu: unsigned product.
  - div: signed, quotient truncated toward zero, remainder takes the dividend's sign; lo = quotient, hi = remainder. Overflow case (most negative / -1): lo = most negative value, hi = 0.
  - divu: unsigned.
  - Divide by zero: pend = current hi/lo, so HI/LO are unchanged. Busy still runs DIV_CYCLES.
- mthi/mtlo: hi<=rs_val or lo<=rs_val at the edge when e_valid & !busy. Ignored while busy; the stall prevents this from occurring legally.
- stall = is_md(d_instr) & (busy | start). A start in E together with an MD instr in D stalls D.
- An MD instr in E while busy cannot occur given stall; if it does, it is ignored and no restart happens.
- mf_data does not check busy. The stall guarantees HI/LO are final when read.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined, op=011100 (SPECIAL2) is decoded with funct:
  - madd 000000: {hi,lo} += signed rs·rt
  - maddu 000001: {hi,lo} += unsigned rs·rt
  - msub 000100: {hi,lo} -= signed rs·rt
  - msubu 000101: {hi,lo} -= unsigned rs·rt
- Accumulation is modulo 2^(2·DATA_W). The accumulator base is hi/lo at the start edge. Busy = MULT_CYCLES.
- These ops count in is_md and start.
- When undefined, these encodings are non-MD: no start, no stall, HI/LO untouched.

Decomposition:
- Shared package/header md_defs:
  - opcode constants SPECIAL 000000 and SPECIAL2 011100
  - the 8 (+4) funct constants
  - an md_op enum: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU
- One sub-module md_decode is natural: combinational instr→md_op. It is instantiated twice (E and D) and is reusable by the main control decoder.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3, MULT_CYCLES=5 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7, rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after 10 busy cycles. divu 7/0 → hi/lo unchanged, busy still 10 cycles.
- start div with mflo in D → stall=1 on the start cycle and all 10 busy cycles. stall=0 on the first cycle busy=0, and mf_data equals the new lo.
- mthi rs=0x12345678 with e_valid=1, busy=0 → hi=0x12345678 next cycle. Same with e_valid=0 → hi unchanged.
- Assert reset at busy cycle 3 of a mult → busy=0, hi=lo=0 immediately; no commit after reset release.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd rs=1, rt=1 → hi=1, lo=0. Without the macro, the same instr → no busy, no stall, hi/lo unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared HI/LO-unit definitions: opcode and funct encodings plus the decoded
// operation enum used by md_decode and md_unit (and reusable by the main decoder).
// The SPECIAL2 multiply-accumulate encodings are only meaningful when the
// MDU_MADD_EN macro is defined.
package md_defs;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [5:0] FN_MADD  = 6'b000000;
  localparam logic [5:0] FN_MADDU = 6'b000001;
  localparam logic [5:0] FN_MSUB  = 6'b000100;
  localparam logic [5:0] FN_MSUBU = 6'b000101;

  typedef enum logic [3:0] {
    NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO,
    MADD, MADDU, MSUB, MSUBU
  } md_op_e;

  // Any HI/LO-class instruction (these are the ones that must wait for busy).
  function automatic logic is_md(md_op_e op);
    return op != NONE;
  endfunction

  // Operations that launch the multi-cycle engine.
  function automatic logic is_launch(md_op_e op);
    return (op == MULT) || (op == MULTU) || (op == DIV)  || (op == DIVU) ||
           (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

endpackage

// File: rtl/md_unit_decode.sv
// md_decode: combinational instruction word -> md_op_e.
// SPECIAL2 madd/maddu/msub/msubu are recognised only with MDU_MADD_EN defined;
// otherwise those encodings decode as NONE.
module md_decode
  import md_defs::*;
(
  input  logic [31:0] instr,
  output md_op_e      op
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  // Map opcode/funct to the operation; anything unrecognised is NONE.
  always_comb begin
    op = NONE;
    if (opcode == OP_SPECIAL) begin
      case (funct)
        FN_MULT:  op = MULT;
        FN_MULTU: op = MULTU;
        FN_DIV:   op = DIV;
        FN_DIVU:  op = DIVU;
        FN_MFHI:  op = MFHI;
        FN_MFLO:  op = MFLO;
        FN_MTHI:  op = MTHI;
        FN_MTLO:  op = MTLO;
        default:  op = NONE;
      endcase
    end
`ifdef MDU_MADD_EN
    else if (opcode == OP_SPECIAL2) begin
      case (funct)
        FN_MADD:  op = MADD;
        FN_MADDU: op = MADDU;
        FN_MSUB:  op = MSUB;
        FN_MSUBU: op = MSUBU;
        default:  op = NONE;
      endcase
    end
`endif
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO, busy counter and D-stage
// stall generation. The result is computed at the start edge into pend_hi/lo
// and committed to HI/LO when the busy counter expires, which models the
// latency of an iterative unit. Optional macro MDU_MADD_EN adds
// madd/maddu/msub/msubu accumulation into {HI,LO}.
module md_unit
  import md_defs::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       e_instr,
  input  logic              e_valid,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [31:0]       d_instr,
  output logic              busy,
  output logic              start,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mf_data
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(1);
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_NEG1 = '1;

  md_op_e e_op;
  md_op_e d_op;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pend_hi;
  logic [DATA_W-1:0] pend_lo;
  logic [DATA_W-1:0] nxt_hi;
  logic [DATA_W-1:0] nxt_lo;
  logic [CNT_W-1:0]  n_cycles;

  logic signed [DATA_W-1:0]   rs_s;
  logic signed [DATA_W-1:0]   rt_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;

  // Signed divide returning {remainder, quotient}. MIN / -1 would overflow the
  // quotient, so it is pinned to {0, MIN} without ever evaluating the divide.
  function automatic logic [2*DATA_W-1:0] sdiv(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    if ((a == S_MIN) && (b == S_NEG1)) begin
      q = S_MIN;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  md_decode u_dec_e (.instr(e_instr), .op(e_op));
  md_decode u_dec_d (.instr(d_instr), .op(d_op));

  assign rs_s   = rs_val;
  assign rt_s   = rt_val;
  assign prod_s = {{DATA_W{rs_s[DATA_W-1]}}, rs_s} * {{DATA_W{rt_s[DATA_W-1]}}, rt_s};
  assign prod_u = {{DATA_W{1'b0}}, rs_val} * {{DATA_W{1'b0}}, rt_val};

  assign busy    = (cnt != '0);
  assign start   = e_valid && is_launch(e_op) && !busy;
  assign stall   = is_md(d_op) && (busy || start);
  assign mf_data = (e_op == MFHI) ? hi : ((e_op == MFLO) ? lo : '0);

  // Result and latency of the operation presented in E; divide by zero keeps HI/LO.
  always_comb begin
    nxt_hi   = hi;
    nxt_lo   = lo;
    n_cycles = MULT_N;
    case (e_op)
      MULT:  {nxt_hi, nxt_lo} = prod_s;
      MULTU: {nxt_hi, nxt_lo} = prod_u;
      DIV: begin
        n_cycles = DIV_N;
        if (rt_val != '0) {nxt_hi, nxt_lo} = sdiv(rs_s, rt_s);
      end
      DIVU: begin
        n_cycles = DIV_N;
        if (rt_val != '0) begin
          nxt_lo = rs_val / rt_val;
          nxt_hi = rs_val % rt_val;
        end
      end
`ifdef MDU_MADD_EN
      MADD:  {nxt_hi, nxt_lo} = {hi, lo} + prod_s;
      MADDU: {nxt_hi, nxt_lo} = {hi, lo} + prod_u;
      MSUB:  {nxt_hi, nxt_lo} = {hi, lo} - prod_s;
      MSUBU: {nxt_hi, nxt_lo} = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

  // Busy counter: loaded on start, counts down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (start) cnt <= n_cycles;
    else if (busy)  cnt <= cnt - 1'b1;
  end

  // Pending result captured at the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (start) begin
      pend_hi <= nxt_hi;
      pend_lo <= nxt_lo;
    end
  end

  // HI/LO: commit on the final busy edge, otherwise mthi/mtlo when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (cnt == LAST_N) begin
      hi <= pend_hi;
      lo <= pend_lo;
    end else if (e_valid && !busy) begin
      if (e_op == MTHI) hi <= rs_val;
      if (e_op == MTLO) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default parameters).
// Inputs change after the rising edge, outputs are sampled on the falling edge.
module tb_md_unit;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MADD  = 32'h7000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] e_instr;
  logic        e_valid;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] d_instr;
  logic        busy;
  logic        start;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int errors = 0;
  int checks = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .e_instr(e_instr), .e_valid(e_valid),
    .rs_val(rs_val), .rt_val(rt_val), .d_instr(d_instr),
    .busy(busy), .start(start), .stall(stall),
    .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction in E for one cycle (called at a falling edge).
  task automatic issue(input string tag, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic valid, input logic exp_start);
    e_instr = instr;
    e_valid = valid;
    rs_val  = a;
    rt_val  = b;
    #1;
    check({tag, ".start"}, {31'b0, start}, {31'b0, exp_start});
    @(posedge clk);
    #1;
    e_instr = I_NOP;
    e_valid = 1'b0;
  endtask

  // Count falling edges with busy high; returns at the first idle falling edge.
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    check({tag, ".timeout"}, 32'd1, 32'd0);
  endtask

  int n;
  int stall_low;

  initial begin
    reset   = 1'b1;
    e_instr = I_NOP;
    e_valid = 1'b0;
    rs_val  = '0;
    rt_val  = '0;
    d_instr = I_NOP;
    repeat (2) @(negedge clk);
    check("rst.busy",  {31'b0, busy},  32'd0);
    check("rst.hi",    hi,             32'd0);
    check("rst.lo",    lo,             32'd0);
    check("rst.start", {31'b0, start}, 32'd0);
    check("rst.stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // mult -2 * 3
    issue("mult", I_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    wait_idle("mult", n);
    check("mult.cycles", n,  32'd5);
    check("mult.hi",     hi, 32'hFFFF_FFFF);
    check("mult.lo",     lo, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    issue("multu", I_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    wait_idle("multu", n);
    check("multu.cycles", n,  32'd5);
    check("multu.hi",     hi, 32'h0000_0002);
    check("multu.lo",     lo, 32'hFFFF_FFFA);

    // div -7 / 2 -> q=-3, r=-1
    issue("div", I_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_idle("div", n);
    check("div.cycles", n,  32'd10);
    check("div.hi",     hi, 32'hFFFF_FFFF);
    check("div.lo",     lo, 32'hFFFF_FFFD);

    // divu 7 / 0 -> HI/LO unchanged, full latency
    issue("divu0", I_DIVU, 32'd7, 32'd0, 1'b1, 1'b1);
    wait_idle("divu0", n);
    check("divu0.cycles", n,  32'd10);
    check("divu0.hi",     hi, 32'hFFFF_FFFF);
    check("divu0.lo",     lo, 32'hFFFF_FFFD);

    // div overflow MIN / -1 -> lo=MIN, hi=0
    issue("divovf", I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle("divovf", n);
    check("divovf.hi", hi, 32'h0000_0000);
    check("divovf.lo", lo, 32'h8000_0000);

    // divu 100 / 7 with mflo waiting in D: stall through start and busy
    d_instr = I_MFLO;
    e_instr = I_DIVU;
    e_valid = 1'b1;
    rs_val  = 32'd100;
    rt_val  = 32'd7;
    #1;
    check("stall.start", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    e_instr = I_NOP;
    e_valid = 1'b0;
    stall_low = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (!stall) stall_low++;
    end
    check("stall.cycles",  n,                32'd10);
    check("stall.busylow", stall_low,        32'd0);
    check("stall.release", {31'b0, stall},   32'd0);
    e_instr = I_MFLO;
    #1;
    check("mflo.data", mf_data, 32'd14);
    e_instr = I_MFHI;
    #1;
    check("mfhi.data", mf_data, 32'd2);
    e_instr = I_NOP;
    #1;
    check("mfnone.data", mf_data, 32'd0);
    d_instr = I_NOP;
    @(negedge clk);

    // mthi valid, mtlo invalid
    issue("mthi", I_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("mthi.hi", hi, 32'h1234_5678);
    issue("mtlo_inv", I_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("mtlo_inv.lo", lo, 32'd14);

    // reset during busy cycle 3 of a mult
    issue("rstmid", I_MULT, 32'd5, 32'd7, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("rstmid.busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid.busy", {31'b0, busy}, 32'd0);
    check("rstmid.hi",   hi,            32'd0);
    check("rstmid.lo",   lo,            32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rstmid.nocommit_hi", hi,            32'd0);
    check("rstmid.nocommit_lo", lo,            32'd0);
    check("rstmid.idle",        {31'b0, busy}, 32'd0);

    // madd on hi=0, lo=0xFFFFFFFF with 1*1
    issue("mtlo", I_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("mtlo.lo", lo, 32'hFFFF_FFFF);
    d_instr = I_MADD;
`ifdef MDU_MADD_EN
    e_instr = I_MADD;
    e_valid = 1'b1;
    rs_val  = 32'd1;
    rt_val  = 32'd1;
    #1;
    check("madd.stall", {31'b0, stall}, 32'd1);
    d_instr = I_NOP;
    issue("madd", I_MADD, 32'd1, 32'd1, 1'b1, 1'b1);
    wait_idle("madd", n);
    check("madd.cycles", n,  32'd5);
    check("madd.hi",     hi, 32'd1);
    check("madd.lo",     lo, 32'd0);
`else
    e_instr = I_MADD;
    e_valid = 1'b1;
    rs_val  = 32'd1;
    rt_val  = 32'd1;
    #1;
    check("madd.stall", {31'b0, stall}, 32'd0);
    d_instr = I_NOP;
    issue("madd", I_MADD, 32'd1, 32'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("madd.busy", {31'b0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("madd.hi", hi, 32'd0);
    check("madd.lo", lo, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
